// File: rtl/secded_mem_sequencer.sv
// secded_mem_sequencer: SECDED(16,11) block decoder sharing data memory through req/gnt.
// Define SECDED_STATS_EN to add saturating single/double error counters (sec_count, ded_count).
module secded_mem_sequencer #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 64,
  parameter int DST_BASE  = 94,
  parameter int AW        = 8
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          start,
  output logic          halt,
  output logic          busy,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    mem_wdata,
`ifdef SECDED_STATS_EN
  output logic [7:0]    sec_count,
  output logic [7:0]    ded_count,
`endif
  output logic          mem_wr_en
);
  localparam logic [2:0] IDLE = 3'd0, RD_LO = 3'd1, RD_HI = 3'd2, DEC = 3'd3;
  localparam logic [2:0] WR_LO = 3'd4, WR_HI = 3'd5, DONE = 3'd6;
  // Hamming positions of d1..d11, d1 in the low nibble
  localparam logic [43:0] POS = {4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3};
  logic [2:0] state;
  logic [6:0] idx;
  logic [7:0] lo, hi;
  logic [15:0] cw, res, res_next;
  logic [3:0] s;
  logic p;
  logic [10:0] fl;
  logic [AW-1:0] src, dst;
  assign cw = {hi, lo};
  always_comb begin
    s = 4'd0;
    for (int k = 1; k < 16; k++) s = s ^ (cw[k] ? 4'(k) : 4'd0);
    p = ^cw;
    for (int j = 0; j < 11; j++) fl[j] = p && (s == POS[4*j +: 4]);
  end
  assign res_next = {(s != 4'd0) && !p, 4'd0, {cw[15:9], cw[7:5], cw[3]} ^ fl};
  assign src = AW'(SRC_BASE + 2 * int'(idx));
  assign dst = AW'(DST_BASE + 2 * int'(idx));
  always_comb begin
    busy = !(state == IDLE || state == DONE);
    mem_req = busy;
    halt = state == DONE;
    mem_addr = state == RD_LO ? src : state == RD_HI ? src + AW'(1) :
               state == WR_LO ? dst : state == WR_HI ? dst + AW'(1) : '0;
    mem_wdata = state == WR_LO ? res[7:0] : state == WR_HI ? res[15:8] : 8'd0;
    mem_wr_en = (state == WR_LO || state == WR_HI) && mem_gnt;
  end
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      idx <= '0;
      lo <= '0;
      hi <= '0;
      res <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= RD_LO;
          idx <= '0;
        end
        RD_LO: if (mem_gnt) begin
          lo <= mem_rdata;
          state <= RD_HI;
        end
        RD_HI: if (mem_gnt) begin
          hi <= mem_rdata;
          state <= DEC;
        end
        DEC: begin
          res <= res_next;
          state <= WR_LO;
        end
        WR_LO: if (mem_gnt) state <= WR_HI;
        WR_HI: if (mem_gnt) begin
          if (idx == 7'(NUM_WORDS - 1)) state <= DONE;
          else begin
            idx <= idx + 7'd1;
            state <= RD_LO;
          end
        end
        default: state <= IDLE;
      endcase
    end
`ifdef SECDED_STATS_EN
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      sec_count <= 8'd0;
      ded_count <= 8'd0;
    end else if (!busy && start) begin
      sec_count <= 8'd0;
      ded_count <= 8'd0;
    end else if (state == DEC) begin
      if (p && sec_count != 8'hFF) sec_count <= sec_count + 8'd1;
      if (res_next[15] && ded_count != 8'hFF) ded_count <= ded_count + 8'd1;
    end
`endif
endmodule
